// File: rtl/sprite_rom_sequencer.sv
// Sprite ROM sequencer: walks a 1-bit bitmap ROM row-major and emits colour-expanded
// pixels tagged with x/y/last through a 2-entry, credit-controlled output buffer.
module sprite_rom_sequencer #(
  parameter int ADDR_WIDTH  = 17,
  parameter int DIM_WIDTH   = 9,
  parameter int COLOR_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   abort,
  input  logic [ADDR_WIDTH-1:0]  base_addr,
  input  logic [DIM_WIDTH-1:0]   img_w,
  input  logic [DIM_WIDTH-1:0]   img_h,
  input  logic [COLOR_WIDTH-1:0] fg_color,
  input  logic [COLOR_WIDTH-1:0] bg_color,
  output logic                   busy,
  output logic                   done,
  output logic [ADDR_WIDTH-1:0]  rom_addr,
  input  logic                   rom_data,
  output logic                   pix_valid,
  input  logic                   pix_ready,
  output logic [COLOR_WIDTH-1:0] pix_data,
  output logic [DIM_WIDTH-1:0]   pix_x,
  output logic [DIM_WIDTH-1:0]   pix_y,
  output logic                   pix_last
);
  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;
  typedef struct packed {
    logic [COLOR_WIDTH-1:0] data;
    logic [DIM_WIDTH-1:0]   x;
    logic [DIM_WIDTH-1:0]   y;
    logic                   last;
  } pix_t;

  state_t                 state, state_nxt;
  logic [DIM_WIDTH-1:0]   w_q, h_q, ix, iy, fx, fy;
  logic [COLOR_WIDTH-1:0] fg_q, bg_q;
  logic                   fl, infl;
  pix_t                   buf_q [2];
  pix_t                   in_pix;
  logic [1:0]             cnt, occ;
  logic                   start_ok, zero_dim, kill, pop, issue, x_end, last_issue;

  assign start_ok   = (state == IDLE) && start;
  assign zero_dim   = (img_w == '0) || (img_h == '0);
  assign kill       = abort && (state != IDLE);
  assign pop        = pix_valid && pix_ready;
  // Slots already spoken for next cycle: buffered + in flight, minus the one leaving now.
  assign occ        = cnt + {1'b0, infl} - {1'b0, pop};
  assign issue      = (state == FETCH) && !abort && (occ < 2'd2);
  assign x_end      = (ix == w_q - DIM_WIDTH'(1));
  assign last_issue = x_end && (iy == h_q - DIM_WIDTH'(1));
  assign in_pix     = {rom_data ? fg_q : bg_q, fx, fy, fl};

  assign busy      = (state == FETCH) || (state == DRAIN);
  assign done      = (state == DONE);
  assign pix_valid = (cnt != 2'd0);
  assign pix_data  = buf_q[0].data;
  assign pix_x     = buf_q[0].x;
  assign pix_y     = buf_q[0].y;
  assign pix_last  = buf_q[0].last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (start) state_nxt = zero_dim ? DONE : FETCH;
      FETCH: if (abort) state_nxt = IDLE;
             else if (issue && last_issue) state_nxt = DRAIN;
      // Finish in the same cycle the last pixel hands off, so done follows immediately.
      DRAIN: if (abort) state_nxt = IDLE;
             else if (!infl && (cnt == 2'd0 || (cnt == 2'd1 && pop))) state_nxt = DONE;
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_q <= '0; h_q <= '0; fg_q <= '0; bg_q <= '0;
      ix <= '0; iy <= '0; fx <= '0; fy <= '0; fl <= 1'b0;
      infl <= 1'b0; rom_addr <= '0; cnt <= '0;
      buf_q[0] <= '0; buf_q[1] <= '0;
    end else begin
      infl <= issue;
      if (start_ok) begin
        w_q <= img_w; h_q <= img_h; fg_q <= fg_color; bg_q <= bg_color;
        if (!zero_dim) begin
          rom_addr <= base_addr;
          ix <= '0; iy <= '0;
        end
      end
      if (issue) begin
        fx <= ix; fy <= iy; fl <= last_issue;
        rom_addr <= rom_addr + ADDR_WIDTH'(1);
        if (x_end) begin
          ix <= '0;
          iy <= iy + DIM_WIDTH'(1);
        end else begin
          ix <= ix + DIM_WIDTH'(1);
        end
      end
      if (kill) cnt <= '0;
      else begin
        case ({pop, infl})
          2'b11: if (cnt == 2'd2) begin
                   buf_q[0] <= buf_q[1];
                   buf_q[1] <= in_pix;
                 end else begin
                   buf_q[0] <= in_pix;
                 end
          2'b10: begin
                   buf_q[0] <= buf_q[1];
                   cnt <= cnt - 2'd1;
                 end
          2'b01: begin
                   buf_q[cnt[0]] <= in_pix;
                   cnt <= cnt + 2'd1;
                 end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_sprite_rom_sequencer.sv
// Directed bench for sprite_rom_sequencer: behavioural ROM, negedge drive/sample,
// pixel scoreboard built from the bench's own ROM image.
module tb_sprite_rom_sequencer;
  logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, abort = 1'b0;
  logic [16:0] base_addr = '0;
  logic [8:0]  img_w = '0, img_h = '0;
  logic [15:0] fg_color = '0, bg_color = '0;
  logic        busy, done, rom_data = 1'b0, pix_valid, pix_ready = 1'b1, pix_last;
  logic [16:0] rom_addr;
  logic [15:0] pix_data;
  logic [8:0]  pix_x, pix_y;

  sprite_rom_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .base_addr(base_addr),
    .img_w(img_w), .img_h(img_h), .fg_color(fg_color), .bg_color(bg_color),
    .busy(busy), .done(done), .rom_addr(rom_addr), .rom_data(rom_data),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data),
    .pix_x(pix_x), .pix_y(pix_y), .pix_last(pix_last)
  );

  always #5 clk = ~clk;

  logic rom [0:131071];
  always @(posedge clk) rom_data <= rom[rom_addr];

  int total = 0, bad = 0, cyc = 0;
  int rdy_mode = 0, acc = 0, done_cnt = 0, done_cyc = 0, valid_cnt = 0, busy_cnt = 0;
  bit track = 0, stalled = 0;
  logic [34:0] held;
  logic [16:0] cur_base;
  logic [34:0] obs_q [$];
  int          obs_cyc [$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  // One cycle: sample at negedge, pick ready for the coming edge, log handshakes.
  task automatic tick();
    logic [16:0] outst;
    @(negedge clk);
    cyc++;
    if (stalled) chk("hold", 64'({pix_valid, pix_data, pix_x, pix_y, pix_last}), 64'({1'b1, held}));
    if (track && busy) begin
      outst = rom_addr - cur_base - acc[16:0];
      chk("credit", 64'(outst <= 17'd2), 64'(1));
    end
    pix_ready = (rdy_mode == 0) ? 1'b1 : ((cyc % 4 == 0) || (cyc % 4 == 3));
    if (pix_valid && pix_ready) begin
      obs_q.push_back({pix_data, pix_x, pix_y, pix_last});
      obs_cyc.push_back(cyc);
      acc++;
    end
    stalled = pix_valid && !pix_ready;
    held    = {pix_data, pix_x, pix_y, pix_last};
    if (pix_valid) valid_cnt++;
    if (busy) busy_cnt++;
    if (done) begin done_cnt++; done_cyc = cyc; end
  endtask

  task automatic clear();
    obs_q.delete(); obs_cyc.delete();
    acc = 0; done_cnt = 0; valid_cnt = 0; busy_cnt = 0; stalled = 0;
  endtask

  task automatic run_job(input logic [16:0] b, input logic [8:0] w, input logic [8:0] h,
                         input logic [15:0] fg, input logic [15:0] bg, input int mode,
                         input bit poke, output int s);
    int n;
    logic [16:0] a;
    logic [34:0] e;
    clear(); rdy_mode = mode; cur_base = b; track = 1;
    base_addr = b; img_w = w; img_h = h; fg_color = fg; bg_color = bg;
    start = 1'b1; s = cyc; tick(); start = 1'b0;
    while (done_cnt == 0 && cyc - s < 3000) begin
      if (poke && cyc - s == 4) begin
        start = 1'b1; base_addr = 17'h0; img_w = 9'd1; fg_color = 16'h1234;
      end else start = 1'b0;
      tick();
    end
    start = 1'b0;
    chk("done_seen", 64'(done_cnt != 0), 64'(1));
    tick(); tick();
    chk("done_once", 64'(done_cnt), 64'(1));
    n = int'(w) * int'(h);
    chk("count", 64'(obs_q.size()), 64'(n));
    for (int k = 0; k < n && k < obs_q.size(); k++) begin
      a = b + k[16:0];
      e = {rom[a] ? fg : bg, 9'(k % int'(w)), 9'(k / int'(w)), k == n - 1};
      chk("pix", 64'(obs_q[k]), 64'(e));
    end
    if (n > 0 && obs_q.size() > 0) begin
      chk("done_lat", 64'(done_cyc), 64'(obs_cyc[obs_q.size()-1] + 1));
      if (mode == 0) chk("first_lat", 64'(obs_cyc[0]), 64'(s + 3));
    end
    track = 0;
  endtask

  logic [15:0] t1_data [8] = '{16'hFFFF, 16'h0000, 16'hFFFF, 16'hFFFF,
                               16'h0000, 16'h0000, 16'h0000, 16'hFFFF};
  logic [7:0]  t1_bits = 8'b1000_1101;  // ROM[0x10] in bit 0
  logic [3:0]  t3_bits = 4'b1001;        // ROM[0x1FFFE], [0x1FFFF], [0], [1] from bit 0

  initial begin
    int s;
    logic [16:0] snap;
    for (int i = 0; i < 131072; i++) rom[i] = i[0] ^ i[2] ^ i[5] ^ i[9];
    for (int i = 0; i < 8; i++) rom[17'h10 + i] = t1_bits[i];
    rom[17'h1FFFE] = t3_bits[0]; rom[17'h1FFFF] = t3_bits[1];
    rom[17'h00000] = t3_bits[2]; rom[17'h00001] = t3_bits[3];

    tick(); tick();
    chk("rst_valid", 64'(pix_valid), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_addr", 64'(rom_addr), 64'(0));
    chk("rst_pix", 64'({pix_data, pix_x, pix_y, pix_last}), 64'(0));
    rst_n = 1'b1;
    tick();

    // 4x2 with fixed ready and hand table
    run_job(17'h00010, 9'd4, 9'd2, 16'hFFFF, 16'h0000, 0, 0, s);
    for (int k = 0; k < 8 && k < obs_q.size(); k++) begin
      chk("t1_data", 64'(obs_q[k][34:19]), 64'(t1_data[k]));
      chk("t1_gap", 64'(obs_cyc[k]), 64'(s + 3 + k));
    end

    // same job under 1,0,0,1 backpressure, with a start poked mid-job
    run_job(17'h00010, 9'd4, 9'd2, 16'hFFFF, 16'h0000, 1, 1, s);

    // address wrap
    run_job(17'h1FFFE, 9'd4, 9'd1, 16'hABCD, 16'h1357, 0, 0, s);
    chk("t3_bits", 64'({obs_q.size() > 3 ? obs_q[3][34:19] : 16'h0,
                        obs_q.size() > 0 ? obs_q[0][34:19] : 16'h0}),
        64'({16'hABCD, 16'hABCD}));

    // zero width: no reads, no pixels
    clear(); snap = rom_addr;
    base_addr = 17'h00055; img_w = 9'd0; img_h = 9'd5;
    start = 1'b1; tick(); start = 1'b0; tick(); tick();
    chk("zw_done", 64'(done_cnt), 64'(1));
    chk("zw_valid", 64'(valid_cnt), 64'(0));
    chk("zw_busy", 64'(busy_cnt), 64'(0));
    chk("zw_addr", 64'(rom_addr), 64'(snap));

    // 1x1 sprite
    run_job(17'h00123, 9'd1, 9'd1, 16'h0F0F, 16'hF0F0, 0, 0, s);

    // abort after 3 pixels, then a clean 16x16
    clear(); rdy_mode = 0;
    base_addr = 17'h00100; img_w = 9'd16; img_h = 9'd16;
    start = 1'b1; s = cyc; tick(); start = 1'b0;
    while (acc < 3 && cyc - s < 100) tick();
    chk("ab_reach", 64'(acc), 64'(3));
    abort = 1'b1; tick(); abort = 1'b0;
    chk("ab_valid", 64'(pix_valid), 64'(0));
    chk("ab_busy", 64'(busy), 64'(0));
    repeat (6) tick();
    chk("ab_nodone", 64'(done_cnt), 64'(0));
    chk("ab_quiet", 64'(acc), 64'(3));
    run_job(17'h00200, 9'd16, 9'd16, 16'hCAFE, 16'h0BAD, 0, 0, s);

    // async reset mid-job
    clear(); rdy_mode = 0;
    base_addr = 17'h00300; img_w = 9'd16; img_h = 9'd16;
    start = 1'b1; tick(); start = 1'b0;
    repeat (10) tick();
    #1 rst_n = 1'b0;
    #1;
    chk("ar_busy", 64'(busy), 64'(0));
    chk("ar_valid", 64'(pix_valid), 64'(0));
    chk("ar_addr", 64'(rom_addr), 64'(0));
    chk("ar_pix", 64'({done, pix_data, pix_x, pix_y, pix_last}), 64'(0));
    tick();
    rst_n = 1'b1;
    tick();
    run_job(17'h00040, 9'd3, 9'd2, 16'h7777, 16'h8888, 1, 0, s);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/sprite_rom_sequencer.md
Name: sprite_rom_sequencer

Overview:
Sequences reads from a single-port 1-bit bitmap block ROM (registered read, 1-cycle latency) to render a rectangular W x H sprite into an RGB565 pixel stream for the LCD compositor. Expands each ROM bit to the foreground or background colour, tags each pixel with x/y/last, and honours downstream valid/ready backpressure without losing or duplicating ROM data. Sits between the game-logic command path (start/params) and the LCD pixel pipeline.

Parameters:
ADDR_WIDTH, 17, ROM address width; addresses wrap modulo 2**ADDR_WIDTH.
DIM_WIDTH, 9, width of img_w/img_h and of pix_x/pix_y.
COLOR_WIDTH, 16, output pixel width (RGB565).

Ports:
clk  input  1  system clock; all logic on rising edge.
rst_n  input  1  asynchronous active-low reset.
start  input  1  one-cycle command strobe; sampled only in IDLE.
abort  input  1  synchronous abort; highest priority after reset.
base_addr  input  ADDR_WIDTH  ROM address of pixel (0,0); latched on accepted start.
img_w  input  DIM_WIDTH  sprite width in pixels; latched on start.
img_h  input  DIM_WIDTH  sprite height in pixels; latched on start.
fg_color  input  COLOR_WIDTH  colour for ROM bit 1; latched on start.
bg_color  input  COLOR_WIDTH  colour for ROM bit 0; latched on start.
busy  output  1  high from the cycle after an accepted start until done or abort.
done  output  1  one-cycle pulse after the final pixel handshake.
rom_addr  output  ADDR_WIDTH  address to ROM.
rom_data  input  1  ROM data; valid the cycle after the address was presented.
pix_valid  output  1  output pixel valid.
pix_ready  input  1  downstream ready.
pix_data  output  COLOR_WIDTH  expanded pixel colour.
pix_x  output  DIM_WIDTH  column of pix_data, 0..img_w-1.
pix_y  output  DIM_WIDTH  row of pix_data, 0..img_h-1.
pix_last  output  1  high with the final pixel (x=img_w-1, y=img_h-1).

Behaviour:
- Reset (async, rst_n=0): state IDLE; busy=0, done=0, pix_valid=0, pix_data=0, pix_x=0, pix_y=0, pix_last=0, rom_addr=0; output buffer and in-flight flag cleared.
- States: IDLE, FETCH, DRAIN, DONE.
- IDLE: start=1 latches parameters. If img_w==0 or img_h==0: go to DONE, no pixels, no ROM reads. Otherwise go to FETCH with issue counter (x,y)=(0,0) and rom_addr=base_addr.
- FETCH: issue one ROM read per cycle when credit allows. Credit rule: buffer depth 2; issue only when (buffer occupancy + in-flight read) < 2, counting an output handshake in the same cycle as freeing a slot. rom_addr advances by 1 per issued read (linear, row-major, wrap at 2**ADDR_WIDTH). After issuing pixel (img_w-1, img_h-1), go to DRAIN.
- Returned rom_data is captured the cycle after issue, expanded (1 -> fg_color, 0 -> bg_color), and pushed with its x/y/last tags. Pixels leave in issue order.
- Output: the buffer head drives pix_*; pix_valid=1 while the buffer is non-empty. A handshake occurs on pix_valid && pix_ready. While pix_valid=1 and pix_ready=0, pix_data/pix_x/pix_y/pix_last hold stable.
- Latency: with pix_ready held high, first pix_valid two cycles after start, then one pixel per cycle, no bubbles.
- DRAIN: no issues; wait for the buffer to empty and no read in flight, then go to DONE.
- DONE: done=1 for exactly one cycle, busy=0, return to IDLE. start is accepted again the cycle after done.
- start while busy: ignored, with no effect on latched parameters.
- abort=1 in any non-IDLE state: next cycle IDLE; buffer flushed; pix_valid=0; in-flight ROM data discarded; no done pulse. abort in IDLE has no effect. abort and start together in IDLE: start wins.
- Counters: x wraps to 0 at img_w-1 and y increments. pix_last is set only on the final pixel.
- Single-pixel sprite (1x1): exactly one pixel, with pix_last=1.

Test Plan:
1. base_addr=0x00010, w=4, h=2, ROM[0x10..0x17]=1,0,1,1,0,0,0,1, fg=0xFFFF, bg=0x0000, ready=1 -> 8 pixels on consecutive cycles starting 2 cycles after start, data F,0,F,F,0,0,0,F, x/y row-major, last only on (3,1), done 1 cycle after the last handshake.
2. Same job, pix_ready toggling 1,0,0,1 repeating -> identical pixel sequence, outputs stable during stalls, no drop or duplicate, rom_addr never more than 2 ahead of the accepted count.
3. base_addr=0x1FFFE, w=4, h=1 -> ROM addresses 0x1FFFE, 0x1FFFF, 0x00000, 0x00001.
4. w=0, h=5 -> no ROM read, no pix_valid, done pulses, busy=0 within 2 cycles.
5. abort after 3 pixels of a 16x16 job, with ready=1 -> pix_valid=0 the next cycle, no done, IDLE; a new start then runs a full 256-pixel job correctly.
6. rst_n deasserted mid-job -> all outputs go to reset values immediately (async); a start after reset release completes normally.
